// File: rtl/add_round_key_stream_pkg.sv
// +--------------------------------------------------------------------------+
// | add_round_key_stream_pkg : shared types and constants for the AES        |
// | AddRoundKey stream stage.                                                |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package add_round_key_stream_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_ROUND_W = 4;

  typedef enum logic [1:0] {
    ARK_IDLE = 2'd0,
    ARK_BUSY = 2'd1,
    ARK_HOLD = 2'd2
  } ark_state_t;

  // FIPS-197 Appendix B round-0 AddRoundKey vector
  localparam logic [AES_BLOCK_W-1:0] FIPS_DATA   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [AES_BLOCK_W-1:0] FIPS_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [AES_BLOCK_W-1:0] FIPS_RESULT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

endpackage

`default_nettype wire

// File: rtl/add_round_key_stream_if.sv
// +--------------------------------------------------------------------------+
// | add_round_key_stream_if : valid/ready input and output channels of the   |
// | AddRoundKey stage.                                                       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface add_round_key_stream_if #(
  parameter int BLOCK_W = 128,
  parameter int ROUND_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] data_in;
  logic [BLOCK_W-1:0] key_in;
  logic [ROUND_W-1:0] round_in;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] data_out;
  logic [ROUND_W-1:0] round_out;
  logic               done;

  modport master (
    output in_valid, data_in, key_in, round_in, out_ready,
    input  in_ready, out_valid, data_out, round_out, done
  );

  modport slave (
    input  in_valid, data_in, key_in, round_in, out_ready,
    output in_ready, out_valid, data_out, round_out, done
  );
endinterface

`default_nettype wire

// File: rtl/add_round_key_stream_lane_xor.sv
// +--------------------------------------------------------------------------+
// | add_round_key_stream_lane_xor : selects one LANE_W lane of data and key  |
// | and XORs them; lane 0 is the least significant lane.                     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module add_round_key_stream_lane_xor #(
  parameter int BLOCK_W = 128,
  parameter int LANE_W  = 32,
  parameter int BEAT_W  = 2
) (
  input  logic [BLOCK_W-1:0] data_i,
  input  logic [BLOCK_W-1:0] key_i,
  input  logic [BEAT_W-1:0]  beat_i,
  output logic [LANE_W-1:0]  lane_o,
  output logic [BEAT_W-1:0]  lane_idx_o
);
  assign lane_o     = data_i[int'(beat_i)*LANE_W +: LANE_W] ^ key_i[int'(beat_i)*LANE_W +: LANE_W];
  assign lane_idx_o = beat_i;
endmodule

`default_nettype wire

// File: rtl/add_round_key_stream.sv
// +--------------------------------------------------------------------------+
// | add_round_key_stream : AES AddRoundKey over BLOCK_W/LANE_W beats with    |
// | valid/ready handshakes and a round tag carried alongside each block.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module add_round_key_stream
  import add_round_key_stream_pkg::*;
#(
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int LANE_W  = 32,
  parameter int ROUND_W = AES_ROUND_W
) (
  input  logic                   clk,
  input  logic                   reset,
  add_round_key_stream_if.slave  bus
);
  localparam int              NBEATS    = BLOCK_W / LANE_W;
  localparam int              BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  if (BLOCK_W % LANE_W != 0) begin : g_lane_check
    $fatal(1, "add_round_key_stream: LANE_W must divide BLOCK_W");
  end

  ark_state_t         state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [BLOCK_W-1:0] result_q, result_d;
  logic               ready_en_q;

  logic [LANE_W-1:0]  lane_res;
  logic [BEAT_W-1:0]  lane_idx;
  logic               in_ready;
  logic               accept;

  add_round_key_stream_lane_xor #(
    .BLOCK_W (BLOCK_W),
    .LANE_W  (LANE_W),
    .BEAT_W  (BEAT_W)
  ) u_lane_xor (
    .data_i     (data_q),
    .key_i      (key_q),
    .beat_i     (beat_q),
    .lane_o     (lane_res),
    .lane_idx_o (lane_idx)
  );

  // ready_en_q holds in_ready low for the cycle following a reset edge
  assign in_ready = ready_en_q &
                    ((state_q == ARK_IDLE) | ((state_q == ARK_HOLD) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARK_IDLE;
      beat_q     <= '0;
      data_q     <= '0;
      key_q      <= '0;
      round_q    <= '0;
      result_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      data_q     <= data_d;
      key_q      <= key_d;
      round_q    <= round_d;
      result_q   <= result_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    data_d   = data_q;
    key_d    = key_q;
    round_d  = round_q;
    result_d = result_q;
    unique case (state_q)
      ARK_IDLE: begin
        if (accept) begin
          data_d  = bus.data_in;
          key_d   = bus.key_in;
          round_d = bus.round_in;
          beat_d  = '0;
          state_d = ARK_BUSY;
        end
      end
      ARK_BUSY: begin
        result_d[int'(lane_idx)*LANE_W +: LANE_W] = lane_res;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = ARK_HOLD;
        end else begin
          beat_d  = beat_q + BEAT_W'(1);
        end
      end
      ARK_HOLD: begin
        if (bus.out_ready) begin
          if (accept) begin
            data_d  = bus.data_in;
            key_d   = bus.key_in;
            round_d = bus.round_in;
            beat_d  = '0;
            state_d = ARK_BUSY;
          end else begin
            state_d = ARK_IDLE;
          end
        end
      end
      default: state_d = ARK_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ARK_HOLD);
  assign bus.done      = (state_q == ARK_HOLD) & bus.out_ready;
  assign bus.data_out  = result_q;
  assign bus.round_out = round_q;

endmodule

`default_nettype wire
